// File: rtl/keypad_entry_tc.sv
// Keypad digit/sign entry with multi-cycle BCD to two's-complement conversion and result handshake.
// Optional backspace key (4'hB) enabled by defining ENTRY_BACKSPACE_EN.
module keypad_entry_tc #(
  parameter int W    = 8,
  parameter int NDIG = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              KEY_VALID,
  input  logic [3:0]        KEY_CODE,
  input  logic              RESULT_ACK,
  output logic              KEY_READY,
  output logic              KEY_ERR,
  output logic [4*NDIG-1:0] DIGITS,
  output logic              NEG,
  output logic [W-1:0]      BinTC,
  output logic              RESULT_VALID,
  output logic              OVF
);

  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {ENTRY, CONV, DONE} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt, r_idx;
  logic [W-1:0]      r_mag;
  logic              r_ovf;
  logic [4*NDIG-1:0] r_digits;
  logic              r_neg, r_kerr, r_valid, r_ovf_out;
  logic [W-1:0]      r_bin;

  logic [3:0]        w_dig;
  logic [W+4:0]      w_prod, w_half;
  logic [W-1:0]      w_lim;
  logic              w_is_digit;

  assign w_is_digit = (KEY_CODE <= 4'd9);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= ENTRY;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ENTRY:   if (KEY_VALID && KEY_CODE == 4'hE) w_next = CONV;
      CONV:    if (r_idx == '0) w_next = DONE;
      DONE:    if (RESULT_ACK) w_next = ENTRY;
      default: w_next = ENTRY;
    endcase
  end

  always_comb begin
    w_dig = '0;
    for (int unsigned i = 1; i <= NDIG; i++)
      if (r_idx == CW'(i)) w_dig = r_digits[4*i-1 -: 4];
  end

  assign w_prod = ({5'b0, r_mag} << 3) + ({5'b0, r_mag} << 1) + (W+5)'(w_dig);
  assign w_half = (W+5)'(1) << (W-1);
  // The limit doubles as the saturated code: 100..0 when negative, 011..1 otherwise.
  assign w_lim  = r_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_mag     <= '0;
      r_ovf     <= 1'b0;
      r_digits  <= '0;
      r_neg     <= 1'b0;
      r_kerr    <= 1'b0;
      r_valid   <= 1'b0;
      r_ovf_out <= 1'b0;
      r_bin     <= '0;
    end else begin
      r_kerr <= 1'b0;
      case (r_state)
        ENTRY: begin
          if (KEY_VALID) begin
            if (w_is_digit) begin
              if (r_cnt != CW'(NDIG)) begin
                r_digits <= (r_digits << 4) | (4*NDIG)'(KEY_CODE);
                r_cnt    <= r_cnt + 1'b1;
              end else begin
                r_kerr <= 1'b1;
              end
            end else begin
              case (KEY_CODE)
                4'hA: r_neg <= ~r_neg;
                4'hC: begin
                  r_digits <= '0;
                  r_cnt    <= '0;
                  r_neg    <= 1'b0;
                end
                4'hE: begin
                  r_idx <= r_cnt;
                  r_mag <= '0;
                  r_ovf <= 1'b0;
                end
`ifdef ENTRY_BACKSPACE_EN
                4'hB: begin
                  if (r_cnt != '0) begin
                    r_digits <= r_digits >> 4;
                    r_cnt    <= r_cnt - 1'b1;
                  end
                end
`endif
                default: ;
              endcase
            end
          end
        end
        CONV: begin
          if (r_idx != '0) begin
            if (w_prod > w_half) begin
              r_ovf <= 1'b1;
              r_mag <= w_half[W-1:0];
            end else begin
              r_mag <= w_prod[W-1:0];
            end
            r_idx <= r_idx - 1'b1;
          end else begin
            if (r_ovf || r_mag > w_lim) begin
              r_bin     <= w_lim;
              r_ovf_out <= 1'b1;
            end else begin
              r_bin <= r_neg ? -r_mag : r_mag;
            end
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (RESULT_ACK) begin
            r_valid   <= 1'b0;
            r_ovf_out <= 1'b0;
            r_digits  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign KEY_READY    = (r_state == ENTRY);
  assign KEY_ERR      = r_kerr;
  assign DIGITS       = r_digits;
  assign NEG          = r_neg;
  assign BinTC        = r_bin;
  assign RESULT_VALID = r_valid;
  assign OVF          = r_ovf_out;

endmodule

// File: doc/keypad_entry_tc.md
# keypad_entry_tc

Parametrised keypad entry unit that collects up to NDIG decimal digits and a sign from a keypad decoder, one key event at a time. On ENTER it converts the BCD entry to a W-bit two's-complement value over several cycles, range-checks and saturates it, and holds the result until the consumer acknowledges it. It sits between the keypad scanner and the arithmetic/output units. It is the generalised, handshaked successor to the fixed 8-bit keypad-to-two's-complement input path.

## Interface
- W, 8: result width in bits (two's complement), W ≥ 4
- NDIG, 3: maximum digits held, NDIG ≥ 1
- CLK  in  1  clock, rising edge
- CLR  in  1  asynchronous active-low clear
- KEY_VALID  in  1  one-cycle key strobe from keypad decoder
- KEY_CODE  in  4  0–9 digit; 4'hA sign toggle; 4'hB backspace; 4'hC clear entry; 4'hE enter; others ignored
- RESULT_ACK  in  1  consumer accepts the held result
- KEY_READY  out  1  high in ENTRY state; keys are only accepted when high
- KEY_ERR  out  1  one-cycle pulse: a digit was rejected because the entry was full
- DIGITS  out  4*NDIG  BCD entry for display, LSD in [3:0]
- NEG  out  1  current sign flag
- BinTC  out  W  converted result
- RESULT_VALID  out  1  BinTC/OVF valid; held until ACK
- OVF  out  1  entry was out of range and BinTC is saturated

## Operation
- States: ENTRY, CONV, DONE. CLR forces ENTRY.
- **ENTRY**, on KEY_VALID:
  - Digit with count<NDIG: DIGITS ← {DIGITS[4*NDIG-5:0], d}; count+1. Leading zeros are counted.
  - Digit with count==NDIG: ignored; KEY_ERR pulses.
  - 4'hA: NEG toggles.
  - 4'hC: DIGITS, count and NEG go to 0.
  - 4'hE: go to CONV; idx←count; mag←0; ovf←0.
- **CONV**, one action per cycle:
  - While idx>0: mag ← mag*10 + DIGITS[4*idx-1 -: 4]; idx−1. The multiply is (mag<<3)+(mag<<1) at width W+5.
  - If the product exceeds 2^(W-1), ovf is set (sticky) and mag saturates at 2^(W-1).
  - When idx==0 (finalise): limit is 2^(W-1) if NEG, else 2^(W-1)−1.
  - In range: BinTC ← NEG ? −mag : mag. Negative zero gives 0.
  - Out of range, or ovf set: BinTC ← NEG ? 1 followed by W−1 zeros : 0 followed by W−1 ones; OVF←1.
  - RESULT_VALID←1; go to DONE.
- **DONE**:
  - Outputs are held and keys are ignored.
  - RESULT_ACK: RESULT_VALID←0, OVF←0, DIGITS←0, count←0, NEG←0; go to ENTRY. BinTC keeps its last value.
- Reset values: BinTC=0, RESULT_VALID=0, OVF=0, KEY_ERR=0, DIGITS=0, NEG=0, KEY_READY=1 (state ENTRY).

## Timing
- All state changes occur on the rising CLK edge, except CLR.
- ENTER sampled at edge k: RESULT_VALID and BinTC update at edge k+count+1. Count 0 gives a latency of 1 and a result of 0.
- KEY_READY is decoded combinationally from state. It falls the cycle after ENTER is sampled and rises the cycle after ACK is sampled.
- KEY_VALID while KEY_READY=0: no effect, no KEY_ERR.
- RESULT_ACK outside DONE: no effect.
- ACK and KEY_VALID in the same DONE cycle: ACK is taken; the key is dropped.
- KEY_ERR is registered and high for exactly one cycle, the cycle after the rejected key.
- CLR low at any time, including mid-CONV: immediately returns to reset values. The pending conversion is discarded.

## Configuration
- ENTRY_BACKSPACE_EN defined:
  - 4'hB in ENTRY with count>0: DIGITS ← {4'h0, DIGITS[4*NDIG-1:4]}; count−1.
  - 4'hB with count 0: no effect.
- ENTRY_BACKSPACE_EN undefined: 4'hB is ignored like the other unused codes, and no backspace logic is generated.

## Test plan
All scenarios use W=8, NDIG=3.
- 1,2,7,E → RESULT_VALID high 4 edges after E; BinTC=8'h7F, OVF=0. ACK → KEY_READY=1, DIGITS=0.
- A,1,2,8,E → BinTC=8'h80, NEG=1, OVF=0.
- 1,2,8,E → BinTC=8'h7F, OVF=1.
- A,9,9,9,E → BinTC=8'h80, OVF=1.
- 4,5,6,7 → KEY_ERR pulse on 7; DIGITS=12'h456.
  - With macro: B → DIGITS=12'h045; E → BinTC=8'h2D after 3 edges.
  - Without macro: B has no effect; E → BinTC=8'h7F, OVF=1.
- 1,2,E; assert CLR during CONV → all outputs at reset values, KEY_READY=1.
  - Repeat 3,E without ACK for 10 cycles → BinTC=8'h03 held, digit keys ignored.
  - E with count 0 → BinTC=0 after 1 edge.
